// File: rtl/ram_dma.sv
// Block copy/fill DMA engine driving the data ram's single port.
// Optional RAM_DMA_BACKWARD_EN: forward-overlapping copies run descending.
module ram_dma #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [DATA_W-1:0] fill_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_load_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_FILL, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic [ADDR_W:0]   remain;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] src_start, dst_start;
    logic              last;

`ifdef RAM_DMA_BACKWARD_EN
    logic              back_q;
    logic              back_d;
    logic [ADDR_W-1:0] len_m1;

    // len_i = 2^ADDR_W truncates to 0, so len_m1 still lands on the last word.
    assign len_m1    = len_i[ADDR_W-1:0] - 1'b1;
    assign back_d    = !mode_i && (dst_i > src_i);
    assign src_start = back_d ? src_i + len_m1 : src_i;
    assign dst_start = back_d ? dst_i + len_m1 : dst_i;
    assign step      = back_q ? {ADDR_W{1'b1}} : {{(ADDR_W-1){1'b0}}, 1'b1};
`else
    assign src_start = src_i;
    assign dst_start = dst_i;
    assign step      = {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

    assign last = (remain == {{ADDR_W{1'b0}}, 1'b1});

    always_ff @(posedge clk_i) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        mem_load_o = 1'b0;
        mem_addr_o = '0;
        mem_data_o = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i == '0) state_d = S_DONE;
                    else if (mode_i) state_d = S_FILL;
                    else             state_d = S_RD;
                end
            end
            S_RD: begin
                busy_o     = 1'b1;
                mem_addr_o = src_ptr;
                state_d    = S_WR;
            end
            S_WR: begin
                busy_o     = 1'b1;
                mem_load_o = 1'b1;
                mem_addr_o = dst_ptr;
                mem_data_o = wdata;
                state_d    = last ? S_DONE : S_RD;
            end
            S_FILL: begin
                busy_o     = 1'b1;
                mem_load_o = 1'b1;
                mem_addr_o = dst_ptr;
                mem_data_o = wdata;
                if (last) state_d = S_DONE;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Copy vs fill is carried by the RD/WR vs FILL states, so no mode register is kept.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            remain  <= '0;
            wdata   <= '0;
`ifdef RAM_DMA_BACKWARD_EN
            back_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        src_ptr <= src_start;
                        dst_ptr <= dst_start;
                        remain  <= len_i;
                        wdata   <= mode_i ? fill_i : '0;
`ifdef RAM_DMA_BACKWARD_EN
                        back_q  <= back_d;
`endif
                    end
                end
                S_RD: wdata <= mem_data_i;
                S_WR: begin
                    src_ptr <= src_ptr + step;
                    dst_ptr <= dst_ptr + step;
                    remain  <= remain - 1'b1;
                end
                S_FILL: begin
                    dst_ptr <= dst_ptr + step;
                    remain  <= remain - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dma.sv
// Directed bench for ram_dma: ram model, write scoreboard and cycle-exact done/busy checks.
module tb_ram_dma;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        start_i;
    logic        mode_i;
    logic [14:0] src_i, dst_i;
    logic [15:0] len_i;
    logic [15:0] fill_i;
    logic        busy_o, done_o, mem_load_o;
    logic [14:0] mem_addr_o;
    logic [15:0] mem_data_o, mem_data_i;

    logic [15:0] ram [0:32767];
    logic        tb_we = 1'b0;
    logic [14:0] tb_addr = '0;
    logic [15:0] tb_data = '0;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];

    int total = 0;
    int fails = 0;
    int nw;

    always #5 clk = ~clk;

    ram_dma dut (
        .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i), .mode_i(mode_i),
        .src_i(src_i), .dst_i(dst_i), .len_i(len_i), .fill_i(fill_i),
        .busy_o(busy_o), .done_o(done_o), .mem_load_o(mem_load_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    assign mem_data_i = ram[mem_addr_o];

    always @(posedge clk) begin
        if (mem_load_o)  ram[mem_addr_o] <= mem_data_o;
        else if (tb_we)  ram[tb_addr]    <= tb_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [14:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic push(input logic [14:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        exp_q.push_back(w);
    endtask

    // exp_done = 0: no done pulse expected; rst_c = 0: no reset; poke_c = 0: no stray start.
    task automatic run_op(input string tag, input logic m, input logic [14:0] s, input logic [14:0] d,
                          input logic [15:0] n, input logic [15:0] f, input int exp_done,
                          input int busy_last, input int poke_c, input int rst_c, input int maxc,
                          output int writes);
        wr_t w;
        writes = 0;
        @(posedge clk); #1;
        start_i = 1'b1; mode_i = m; src_i = s; dst_i = d; len_i = n; fill_i = f;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            check($sformatf("%s busy c%0d", tag, c), {31'b0, busy_o}, {31'b0, c <= busy_last});
            check($sformatf("%s done c%0d", tag, c), {31'b0, done_o}, {31'b0, c == exp_done});
            if (mem_load_o) begin
                writes++;
                if (exp_q.size() == 0) begin
                    check($sformatf("%s unexpected write c%0d", tag, c), {17'b0, mem_addr_o}, 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    check($sformatf("%s waddr c%0d", tag, c), {17'b0, mem_addr_o}, {17'b0, w.addr});
                    check($sformatf("%s wdata c%0d", tag, c), {16'b0, mem_data_o}, {16'b0, w.data});
                end
            end
            if (rst_c != 0 && c == rst_c + 1) begin
                check($sformatf("%s rst addr", tag), {17'b0, mem_addr_o}, 32'h0);
                check($sformatf("%s rst data", tag), {16'b0, mem_data_o}, 32'h0);
                check($sformatf("%s rst load", tag), {31'b0, mem_load_o}, 32'h0);
                reset_ni = 1'b1;
            end
            if (rst_c != 0 && c == rst_c) reset_ni = 1'b0;
            if (poke_c != 0) start_i = (c == poke_c);
        end
        start_i = 1'b0;
        check($sformatf("%s scoreboard empty", tag), exp_q.size(), 32'h0);
    endtask

    initial begin
        reset_ni = 1'b0; start_i = 1'b0; mode_i = 1'b0;
        src_i = '0; dst_i = '0; len_i = '0; fill_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'b0, busy_o}, 32'h0);
        check("reset done", {31'b0, done_o}, 32'h0);
        check("reset load", {31'b0, mem_load_o}, 32'h0);
        check("reset addr", {17'b0, mem_addr_o}, 32'h0);
        check("reset data", {16'b0, mem_data_o}, 32'h0);
        #1 reset_ni = 1'b1;

        poke(15'h0104, 16'hAAAA);
        poke(15'h0010, 16'd1); poke(15'h0011, 16'd2); poke(15'h0012, 16'd3);
        poke(15'h0001, 16'h5555);
        for (int i = 0; i < 8; i++) poke(15'h0020 + 15'(i), 16'h00A0 + 16'(i));
        poke(15'h0302, 16'h7777);

        // Fill 4 words
        for (int i = 0; i < 4; i++) push(15'h0100 + 15'(i), 16'hBEEF);
        run_op("fill", 1'b1, 15'h0, 15'h0100, 16'd4, 16'hBEEF, 5, 4, 0, 0, 7, nw);
        check("fill writes", nw, 4);
        for (int i = 0; i < 4; i++) check($sformatf("fill mem%0d", i), {16'b0, ram[15'h0100 + 15'(i)]}, 32'hBEEF);
        check("fill untouched", {16'b0, ram[15'h0104]}, 32'hAAAA);

        // Copy 3 words
        for (int i = 0; i < 3; i++) push(15'h0200 + 15'(i), 16'(i + 1));
        run_op("copy", 1'b0, 15'h0010, 15'h0200, 16'd3, 16'h0, 7, 6, 0, 0, 9, nw);
        check("copy writes", nw, 3);
        for (int i = 0; i < 3; i++) check($sformatf("copy mem%0d", i), {16'b0, ram[15'h0200 + 15'(i)]}, 32'(i + 1));

        // Wrap-around fill
        push(15'h7FFE, 16'h1234); push(15'h7FFF, 16'h1234); push(15'h0000, 16'h1234);
        run_op("wrap", 1'b1, 15'h0, 15'h7FFE, 16'd3, 16'h1234, 4, 3, 0, 0, 6, nw);
        check("wrap mem0", {16'b0, ram[15'h0000]}, 32'h1234);
        check("wrap untouched", {16'b0, ram[15'h0001]}, 32'h5555);

        // Zero length
        run_op("zero", 1'b0, 15'h0010, 15'h0400, 16'd0, 16'h0, 1, 0, 0, 0, 4, nw);
        check("zero writes", nw, 0);

        // Stray start during a busy copy is ignored
        push(15'h0210, 16'd1); push(15'h0211, 16'd2);
        run_op("ignore", 1'b0, 15'h0010, 15'h0210, 16'd2, 16'h0, 5, 4, 2, 0, 10, nw);

        // Reset in cycle 5 of an 8-word copy
        push(15'h0300, 16'h00A0); push(15'h0301, 16'h00A1);
        run_op("rstmid", 1'b0, 15'h0020, 15'h0300, 16'd8, 16'h0, 0, 5, 0, 5, 10, nw);
        check("rstmid writes", nw, 2);
        check("rstmid w0", {16'b0, ram[15'h0300]}, 32'h00A0);
        check("rstmid w1", {16'b0, ram[15'h0301]}, 32'h00A1);
        check("rstmid w2", {16'b0, ram[15'h0302]}, 32'h7777);

        // Forward-overlapping copy
        for (int i = 0; i < 4; i++) poke(15'(i), 16'(i + 1));
`ifdef RAM_DMA_BACKWARD_EN
        push(15'd5, 16'd4); push(15'd4, 16'd3); push(15'd3, 16'd2); push(15'd2, 16'd1);
`else
        push(15'd2, 16'd1); push(15'd3, 16'd2); push(15'd4, 16'd1); push(15'd5, 16'd2);
`endif
        run_op("overlap", 1'b0, 15'd0, 15'd2, 16'd4, 16'h0, 9, 8, 0, 0, 11, nw);
`ifdef RAM_DMA_BACKWARD_EN
        for (int i = 0; i < 4; i++) check($sformatf("overlap mem%0d", i + 2), {16'b0, ram[15'(i + 2)]}, 32'(i + 1));
`else
        for (int i = 0; i < 4; i++) check($sformatf("overlap mem%0d", i + 2), {16'b0, ram[15'(i + 2)]}, 32'((i % 2) + 1));
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
